// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the bit-select mux arbiter and its picker.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_LOCKED
  } arb_state_t;

  // Selector width for a mux of the given data width; never below one bit.
  function automatic int sel_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible (req & ~mask) bit at or after ptr, wrapping.
// Pure logic, no state; reusable by any shared-resource arbiter.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          found
);

  localparam logic [PW:0] N_V = (PW+1)'(N);

  logic [N-1:0] elig;
  logic [PW:0]  idx;

  assign elig = req & ~mask;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= N_V) idx = idx - N_V;
      if (!found && elig[idx[PW-1:0]]) begin
        winner[idx[PW-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the shared bit-select mux: gnt/mux_sel one cycle after req, bit returned one cycle later.
// Optional burst locking under MUX_ARB_LOCK_EN.
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int SIZE = 8,
  localparam int SW   = sel_w(SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*SW-1:0] req_sel,
`ifdef MUX_ARB_LOCK_EN
  input  logic [NREQ-1:0]   req_lock,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic [SW-1:0]     mux_sel,
  input  logic              mux_out,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_bit,
  output logic              busy
);

  localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [SW:0]   SIZE_V  = (SW+1)'(SIZE);
  localparam logic [SW-1:0] SEL_MAX = SW'(SIZE - 1);

  arb_state_t      state, state_nx;
  logic [PW-1:0]   ptr, ptr_nx;
  logic [NREQ-1:0] gnt_nx;
  logic [NREQ-1:0] win;
  logic            found;
  logic [SW-1:0]   win_sel;
  logic [SW-1:0]   sel_nx;
  logic            oor, oor_nx;
  logic            lock_hold;

  // The current grantee is masked so a held request cannot win twice in a row.
  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .mask   (gnt),
    .ptr    (ptr),
    .winner (win),
    .found  (found)
  );

`ifdef MUX_ARB_LOCK_EN
  assign lock_hold = |(gnt & req & req_lock);
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    gnt_nx   = '0;
    case (state)
      ARB_IDLE: begin
        if (found) begin
          state_nx = ARB_GRANT;
          gnt_nx   = win;
        end
      end
      ARB_GRANT, ARB_LOCKED: begin
        if (lock_hold) begin
          state_nx = ARB_LOCKED;
          gnt_nx   = gnt;
        end else if (found) begin
          state_nx = ARB_GRANT;
          gnt_nx   = win;
        end else begin
          state_nx = ARB_IDLE;
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
    // A held lock freezes the pointer; any fresh winner moves it just past itself.
    if (!lock_hold) begin
      for (int i = 0; i < NREQ; i++) begin
        if (win[i] && found) ptr_nx = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_comb begin
    win_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_nx[i]) win_sel = win_sel | req_sel[i*SW +: SW];
    end
    oor_nx = 1'b0;
    sel_nx = mux_sel;
    if (|gnt_nx) begin
      if ({1'b0, win_sel} >= SIZE_V) begin
        oor_nx = 1'b1;
        sel_nx = SEL_MAX;
      end else begin
        sel_nx = win_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      mux_sel   <= '0;
      oor       <= 1'b0;
      rsp_valid <= '0;
      rsp_bit   <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      gnt       <= gnt_nx;
      mux_sel   <= sel_nx;
      oor       <= oor_nx;
      rsp_valid <= gnt;
      rsp_bit   <= (|gnt) & ~oor & mux_out;
    end
  end

  assign busy = |gnt;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter (NREQ=4, SIZE=6): directed scenarios plus random traffic vs an index-level model.
module tb_mux_sel_arbiter;

  localparam int NREQ = 4;
  localparam int SIZE = 6;
  localparam int SW   = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*SW-1:0] req_sel;
`ifdef MUX_ARB_LOCK_EN
  logic [NREQ-1:0]   req_lock;
`endif
  logic [NREQ-1:0]   gnt;
  logic [SW-1:0]     mux_sel;
  logic              mux_out;
  logic [NREQ-1:0]   rsp_valid;
  logic              rsp_bit;
  logic              busy;
  logic [SIZE-1:0]   data;

  always #5 clk = ~clk;

  assign mux_out = data[mux_sel];

  mux_sel_arbiter #(.NREQ(NREQ), .SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_sel   (req_sel),
`ifdef MUX_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .gnt       (gnt),
    .mux_sel   (mux_sel),
    .mux_out   (mux_out),
    .rsp_valid (rsp_valid),
    .rsp_bit   (rsp_bit),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who holds the mux, where the scan starts, what response is in flight.
  int m_gnt = -1;
  int m_ptr = 0;
  int m_sel = 0;
  bit m_oor = 1'b0;
  int m_rsp = -1;
  bit m_rbit = 1'b0;

  function automatic logic [31:0] oh(input int idx);
    return (idx < 0) ? 32'd0 : (32'd1 << idx);
  endfunction

  function automatic int sel_of(input int i);
    return int'((req_sel >> (i * SW)) & 12'h7);
  endfunction

  function automatic bit req_at(input int i);
    return ((req >> i) & 4'h1) != 4'h0;
  endfunction

  task automatic model_reset();
    m_gnt = -1; m_ptr = 0; m_sel = 0; m_oor = 1'b0; m_rsp = -1; m_rbit = 1'b0;
  endtask

  task automatic model_edge();
    int ng;
    int s;
    bit hit;
    m_rbit = (m_gnt >= 0) && !m_oor && (((data >> m_sel) & 6'h1) != 6'h0);
    m_rsp  = m_gnt;
    ng  = -1;
    hit = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    if (m_gnt >= 0 && req_at(m_gnt) && (((req_lock >> m_gnt) & 4'h1) != 4'h0)) begin
      ng  = m_gnt;
      hit = 1'b1;
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (!hit && idx != m_gnt && req_at(idx)) begin
        ng    = idx;
        hit   = 1'b1;
        m_ptr = (idx + 1) % NREQ;
      end
    end
    m_oor = 1'b0;
    if (ng >= 0) begin
      s     = sel_of(ng);
      m_oor = (s >= SIZE);
      m_sel = m_oor ? SIZE - 1 : s;
    end
    m_gnt = ng;
  endtask

  task automatic compare_all();
    chk("gnt", 32'(gnt), oh(m_gnt));
    chk("busy", 32'(busy), 32'(m_gnt >= 0));
    chk("rsp_valid", 32'(rsp_valid), oh(m_rsp));
    if (m_rsp >= 0) chk("rsp_bit", 32'(rsp_bit), 32'(m_rbit));
    if (m_gnt >= 0) chk("mux_sel", 32'(mux_sel), 32'(m_sel));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Asserted between edges so the asynchronous clear is observed before any clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mux_sel", 32'(mux_sel), 32'd0);
    chk("rst_rsp_bit", 32'(rsp_bit), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int g_cnt;
    int r_cnt;
    rst_n   = 1'b0;
    req     = '0;
    req_sel = '0;
    data    = '0;
`ifdef MUX_ARB_LOCK_EN
    req_lock = '0;
`endif
    #12;
    chk("por_gnt", 32'(gnt), 32'd0);
    chk("por_busy", 32'(busy), 32'd0);
    chk("por_rsp_valid", 32'(rsp_valid), 32'd0);
    model_reset();
    rst_n = 1'b1;

    // Single request, bit 5 of 6'h20
    req = 4'b0100;
    req_sel[2*SW +: SW] = 3'd5;
    data = 6'h20;
    step();
    chk("t1_gnt", 32'(gnt), 32'h4);
    chk("t1_mux_sel", 32'(mux_sel), 32'd5);
    req = '0;
    step();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("t1_rsp_bit", 32'(rsp_bit), 32'd1);
    step();

    // All four held: strict rotation, no idle cycles
    do_reset();
    req = 4'hF;
    req_sel = 12'(unsigned'($urandom));
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_order", 32'(gnt), oh(k % NREQ));
      chk("t2_busy", 32'(busy), 32'd1);
    end
    req = '0;
    step();
    step();

    // Pointer wrap after a grant to 2, then a lone held requester
    do_reset();
    req = 4'b0100;
    step();
    req = 4'b1001;
    step();
    chk("t3_wrap3", 32'(gnt), 32'h8);
    step();
    chk("t3_wrap0", 32'(gnt), 32'h1);
    req = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_lone", 32'(gnt), (k % 2 == 0) ? 32'h2 : 32'h0);
    end
    req = '0;
    step();
    step();

    // Out-of-range selector is clamped and its bit forced low
    do_reset();
    req = 4'b0001;
    req_sel[0 +: SW] = 3'd7;
    data = 6'h3F;
    step();
    chk("t4_gnt", 32'(gnt), 32'h1);
    chk("t4_mux_sel", 32'(mux_sel), 32'd5);
    req = '0;
    step();
    chk("t4_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t4_rsp_bit", 32'(rsp_bit), 32'd0);

    // Reset while a response is out; pointer must restart at 0
    do_reset();
    req = 4'b0010;
    step();
    req = '0;
    step();
    do_reset();
    step();
    chk("t5_no_stale", 32'(rsp_valid), 32'd0);
    req = 4'hF;
    step();
    chk("t5_ptr0", 32'(gnt), 32'h1);
    req = '0;
    step();
    step();

`ifdef MUX_ARB_LOCK_EN
    // Locked burst on requester 1 while 0 waits
    do_reset();
    req = 4'b0001;
    step();
    req = '0;
    step();
    req = 4'b0011;
    req_lock = 4'b0010;
    g_cnt = 0;
    r_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 5) req_lock = '0;
      if (k == 6) req = '0;
      step();
      if (gnt[1]) g_cnt++;
      if (rsp_valid[1]) r_cnt++;
      if (k == 5) chk("t6_next", 32'(gnt), 32'h1);
    end
    chk("t6_gnt_cycles", 32'(g_cnt), 32'd4);
    chk("t6_rsp_strobes", 32'(r_cnt), 32'd4);
`else
    g_cnt = 0;
    r_cnt = 0;
`endif

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req     = 4'(unsigned'($urandom)) & 4'(unsigned'($urandom));
      req_sel = 12'(unsigned'($urandom));
      data    = 6'(unsigned'($urandom));
`ifdef MUX_ARB_LOCK_EN
      req_lock = 4'(unsigned'($urandom));
`endif
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
